alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: reset_n  input  1  reset, synchronous and active-low.
REQ-004 Port: in_valid  input  1  ALU result present this cycle.
REQ-005 Port: in_op  input  4  ALU opcode that produced the result.
REQ-006 Port: in_result  input  32  ALU result word.
REQ-007 Port: in_status  input  5  ALU status flags, opaque bit vector.
REQ-008 Port: in_ready  output  1  buffer can accept (not full, or pop this cycle).
REQ-009 Port: out_valid  output  1  head entry available.
REQ-010 Port: out_ready  input  1  consumer accepts head.
REQ-011 Port: out_op  output  4  head opcode.
REQ-012 Port: out_result  output  32  head result.
REQ-013 Port: out_status  output  5  head status.
REQ-014 Port: count  output  5  current occupancy, 0..DEPTH.
REQ-015 Port: sticky_status  output  5  OR of status of all accepted entries since clear.
REQ-016 Port: clear_sticky  input  1  clears sticky_status and overflow.
REQ-017 Port: overflow  output  1  sticky flag, a valid entry was dropped.

Function
REQ-018 Push: in_valid=1, in_op!=4'b0000, and in_ready=1 at a rising edge; entry {op,result,status} written at tail.
REQ-019 in_op=4'b0000 is NOP; never stored, never affects sticky_status or overflow.
REQ-020 Pop: out_valid=1 and out_ready=1 at a rising edge; head advances.
REQ-021 Show-ahead: out_op/out_result/out_status reflect head combinationally from storage; out_valid = (count!=0).
REQ-022 Latency: entry pushed at edge N is visible with out_valid=1 after edge N; no same-cycle bypass when empty.
REQ-023 in_ready = (count<DEPTH) or (out_valid and out_ready).
REQ-024 Full and pop and push same edge: both occur, count unchanged, order preserved.
REQ-025 Empty and push and out_ready=1: push only; out_ready ignored while out_valid=0.
REQ-026 Non-NOP in_valid while in_ready=0: entry dropped, overflow set to 1, storage/count unchanged.
REQ-027 Read/write pointers wrap modulo DEPTH; count tracked separately, width covers DEPTH.
REQ-028 sticky_status <= sticky_status | in_status on each accepted push.
REQ-029 clear_sticky with simultaneous push: sticky_status <= in_status of that push; overflow <= 0 unless that cycle drops, then 1.
REQ-030 Outputs when empty: out_op/out_result/out_status hold last storage content; consumers qualify with out_valid.

Reset
REQ-031 reset_n=0 at an edge: count=0, pointers=0, out_valid=0, sticky_status=0, overflow=0; in_ready=1 after the edge.
REQ-032 Reset mid-operation discards all entries; in-flight push/pop that edge ignored.
REQ-033 Storage array not reset; out_* data undefined until first push.

Structure
REQ-034 Shared package alu_pkg: ALU_OP_W=4, ALU_DATA_W=32, ALU_STATUS_W=5, ALU_OP_NOP=4'b0000, entry record type {op,result,status}.
REQ-035 One sub-module: alu_rb_mem, DEPTH x 41-bit storage, one write port, one async read port.
REQ-036 Control (pointers, count, flags) stays in alu_result_buffer.

Verification
REQ-037 Reset, push op=1 result=32'd11 status=0, op=2 result=32'hFFFF_FFFF status=5'b00010; out_ready=1 -> pops in order, count 1,2,1,0, sticky_status=5'b00010.
REQ-038 Push 4 entries with out_ready=0 -> count=4, in_ready=0; 5th push op=3 -> dropped, overflow=1, count stays 4.
REQ-039 Full, push op=4 result=32'h0070F0F05 with out_ready=1 same edge -> count stays 4, old head out, new entry at tail.
REQ-040 in_valid=1 op=0 result=32'hDEAD -> count unchanged, sticky_status unchanged.
REQ-041 sticky_status=5'b00011, clear_sticky with push status=5'b10000 -> sticky_status=5'b10000, overflow=0.
REQ-042 reset_n=0 with count=3 mid-stream -> next cycle count=0, out_valid=0, overflow=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: field widths, the NOP opcode and the buffered
// entry record used by the result buffer and its storage.
package alu_pkg;

    localparam int ALU_OP_W     = 4;
    localparam int ALU_DATA_W   = 32;
    localparam int ALU_STATUS_W = 5;
    localparam int ALU_COUNT_W  = 5;

    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 4'b0000;

    typedef struct packed {
        logic [ALU_OP_W-1:0]     op;
        logic [ALU_DATA_W-1:0]   result;
        logic [ALU_STATUS_W-1:0] status;
    } alu_entry_t;

    localparam int ALU_ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_rb_mem.sv
// Result-buffer storage: DEPTH entries, one synchronous write port and one
// asynchronous read port so the head is visible without a read cycle.
module alu_rb_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  alu_entry_t    wr_data,
    input  logic [AW-1:0] rd_addr,
    output alu_entry_t    rd_data
);

    alu_entry_t mem_q [DEPTH];

    // NOTE: storage carries no reset; occupancy is tracked by the control
    // logic, so stale contents are never treated as valid data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu_result_buffer.sv
// Show-ahead FIFO for ALU results: filters NOPs, tracks occupancy, ORs the
// status of every accepted entry and flags dropped entries until cleared.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [ALU_OP_W-1:0]     in_op,
    input  logic [ALU_DATA_W-1:0]   in_result,
    input  logic [ALU_STATUS_W-1:0] in_status,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ALU_OP_W-1:0]     out_op,
    output logic [ALU_DATA_W-1:0]   out_result,
    output logic [ALU_STATUS_W-1:0] out_status,
    output logic [ALU_COUNT_W-1:0]  count,
    output logic [ALU_STATUS_W-1:0] sticky_status,
    input  logic                    clear_sticky,
    output logic                    overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ALU_COUNT_W-1:0] DEPTH_C = ALU_COUNT_W'(DEPTH);

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [ALU_COUNT_W-1:0]  count_q, count_d;
    logic [ALU_STATUS_W-1:0] sticky_q, sticky_d;
    logic                    overflow_q, overflow_d;

    logic       is_op, push, pop, drop;
    alu_entry_t wr_entry, head_entry;

    assign is_op     = in_valid && (in_op != ALU_OP_NOP);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    // A pop frees the slot the same edge, so a full buffer still accepts.
    assign in_ready  = (count_q < DEPTH_C) || pop;
    assign push      = is_op && in_ready;
    assign drop      = is_op && !in_ready;

    assign wr_entry = '{op: in_op, result: in_result, status: in_status};

    // NOTE: every next-state signal gets a default first so no latch forms.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + ALU_COUNT_W'(push) - ALU_COUNT_W'(pop);
        sticky_d   = sticky_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (clear_sticky) begin
            sticky_d   = push ? in_status : '0;
            overflow_d = drop;
        end else begin
            if (push) sticky_d = sticky_q | in_status;
            if (drop) overflow_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            overflow_q <= overflow_d;
        end
    end

    alu_rb_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push && reset_n),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (head_entry)
    );

    assign out_op        = head_entry.op;
    assign out_result    = head_entry.result;
    assign out_status    = head_entry.status;
    assign count         = count_q;
    assign sticky_status = sticky_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer (DEPTH=4) with hand-computed expectations.
module tb_alu_result_buffer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_result;
    logic [4:0]  in_status;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [31:0] out_result;
    logic [4:0]  out_status;
    logic [4:0]  count;
    logic [4:0]  sticky_status;
    logic        clear_sticky;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    alu_result_buffer #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_op         (in_op),
        .in_result     (in_result),
        .in_status     (in_status),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op        (out_op),
        .out_result    (out_result),
        .out_status    (out_status),
        .count         (count),
        .sticky_status (sticky_status),
        .clear_sticky  (clear_sticky),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] res,
                         input logic [4:0] st, input logic ordy);
        in_valid  = v;
        in_op     = op;
        in_result = res;
        in_status = st;
        out_ready = ordy;
    endtask

    task automatic check_head(input string tag, input logic [3:0] op, input logic [31:0] res);
        check({tag, "_op"}, 32'(out_op), 32'(op));
        check({tag, "_result"}, out_result, res);
    endtask

    initial begin
        reset_n      = 1'b0;
        clear_sticky = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 5'h0, 1'b0);
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sticky", 32'(sticky_status), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;

        // Two pushes, then drain in order.
        drive(1'b1, 4'h1, 32'd11, 5'b00000, 1'b0);
        tick();
        check("p1_count", 32'(count), 32'd1);
        check("p1_out_valid", 32'(out_valid), 32'd1);
        check_head("p1_head", 4'h1, 32'd11);
        drive(1'b1, 4'h2, 32'hFFFF_FFFF, 5'b00010, 1'b0);
        tick();
        check("p2_count", 32'(count), 32'd2);
        check_head("p2_head", 4'h1, 32'd11);
        drive(1'b0, 4'h0, 32'h0, 5'h0, 1'b1);
        tick();
        check("pop1_count", 32'(count), 32'd1);
        check_head("pop1_head", 4'h2, 32'hFFFF_FFFF);
        check("pop1_status", 32'(out_status), 32'b00010);
        tick();
        check("pop2_count", 32'(count), 32'd0);
        check("pop2_out_valid", 32'(out_valid), 32'd0);
        check("seq_sticky", 32'(sticky_status), 32'b00010);

        // NOP is neither stored nor folded into sticky.
        drive(1'b1, 4'h0, 32'hDEAD, 5'b11111, 1'b0);
        tick();
        check("nop_count", 32'(count), 32'd0);
        check("nop_sticky", 32'(sticky_status), 32'b00010);
        check("nop_overflow", 32'(overflow), 32'd0);

        // Fill to DEPTH with out_ready low.
        drive(1'b1, 4'h5, 32'h101, 5'b00001, 1'b0);
        tick();
        drive(1'b1, 4'h6, 32'h102, 5'b00000, 1'b0);
        tick();
        drive(1'b1, 4'h7, 32'h103, 5'b00000, 1'b0);
        tick();
        drive(1'b1, 4'h8, 32'h104, 5'b00000, 1'b0);
        tick();
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_sticky", 32'(sticky_status), 32'b00011);
        drive(1'b1, 4'h3, 32'h333, 5'b10100, 1'b0);
        tick();
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_count", 32'(count), 32'd4);
        check("drop_sticky", 32'(sticky_status), 32'b00011);
        check_head("drop_head", 4'h5, 32'h101);

        // Full with simultaneous pop and push.
        drive(1'b1, 4'h4, 32'h070F_0F05, 5'b00000, 1'b1);
        #1;
        check("fullpp_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("fullpp_count", 32'(count), 32'd4);
        check_head("fullpp_head", 4'h6, 32'h102);
        drive(1'b0, 4'h0, 32'h0, 5'h0, 1'b1);
        tick();
        check_head("drain1", 4'h7, 32'h103);
        tick();
        check_head("drain2", 4'h8, 32'h104);
        tick();
        check_head("drain3", 4'h4, 32'h070F_0F05);
        check("drain3_count", 32'(count), 32'd1);
        tick();
        check("drain_count", 32'(count), 32'd0);
        check("drain_overflow", 32'(overflow), 32'd1);

        // Clear sticky together with a push.
        clear_sticky = 1'b1;
        drive(1'b1, 4'h9, 32'h99, 5'b10000, 1'b0);
        tick();
        clear_sticky = 1'b0;
        check("clr_sticky", 32'(sticky_status), 32'b10000);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_count", 32'(count), 32'd1);

        // Reset mid-stream with an in-flight push and pop.
        drive(1'b1, 4'hA, 32'hA0, 5'b00100, 1'b0);
        tick();
        drive(1'b1, 4'hB, 32'hB0, 5'b00000, 1'b0);
        tick();
        check("mid_count", 32'(count), 32'd3);
        check("mid_sticky", 32'(sticky_status), 32'b10100);
        reset_n = 1'b0;
        drive(1'b1, 4'hC, 32'hC0, 5'b01000, 1'b1);
        tick();
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_overflow", 32'(overflow), 32'd0);
        check("mrst_sticky", 32'(sticky_status), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;

        // Empty with out_ready high: push only.
        drive(1'b1, 4'hD, 32'h1234, 5'b00001, 1'b1);
        tick();
        check("epush_count", 32'(count), 32'd1);
        check_head("epush_head", 4'hD, 32'h1234);
        drive(1'b0, 4'h0, 32'h0, 5'h0, 1'b1);
        tick();
        check("epop_count", 32'(count), 32'd0);
        check("end_sticky", 32'(sticky_status), 32'b00001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
